root_rank_sched: RTL and testbench

- Per-inference layer sequencer for the root rank module.
- On `start` it walks layers 0..`last_layer`. For each layer it reads the rank-state lookup (`rank_no`, `uv_en`) and emits a stream of compute commands over a valid/ready handshake.
- A low-rank layer gets one command per rank index; a bypassed layer gets a single bypass command.
- Before advancing, it waits for the PE array's layer-done acknowledge, then pulses `done`.

---
 rtl/root_rank_sched_pkg.sv | 18 +
 rtl/root_rank_sched_rank_cmd_gen.sv | 71 +++++++
 rtl/root_rank_sched.sv | 118 +++++++++++
 tb/tb_root_rank_sched.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/root_rank_sched_pkg.sv
// Shared widths, FSM encodings and small helpers for the root rank layer sequencer.
package root_rank_sched_pkg;

  // Default layer-number and rank widths of the rank-state table.
  localparam int LAYER_W_DEF = 3;
  localparam int RANK_W_DEF  = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  // A layer without the UV path, or with a zero rank, collapses to one bypass command.
  function automatic logic is_bypass(input logic uv, input logic rank_zero);
    return !uv || rank_zero;
  endfunction

endpackage

// File: rtl/root_rank_sched_rank_cmd_gen.sv
// Command field generator: holds the layer's rank/UV snapshot and the rank index,
// and produces the command fields, last flag and transfer strobe.
module rank_cmd_gen
  import root_rank_sched_pkg::*;
#(
  parameter int LAYER_W = LAYER_W_DEF,
  parameter int RANK_W  = RANK_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic               issue_i,
  input  logic [RANK_W-1:0]  rank_no_i,
  input  logic               uv_en_i,
  input  logic [LAYER_W-1:0] layer_i,
  input  logic               cmd_ready_i,
  output logic               cmd_valid_o,
  output logic [LAYER_W-1:0] cmd_layer_o,
  output logic [RANK_W-1:0]  cmd_rank_idx_o,
  output logic               cmd_bypass_o,
  output logic               cmd_last_o,
  output logic               xfer_o
);

  logic [RANK_W-1:0] rank_q;
  logic [RANK_W-1:0] idx_q;
  logic [RANK_W-1:0] idx_d;
  logic [RANK_W-1:0] rank_m1;
  logic              uv_q;
  logic              byp;
  logic              last;
  logic              xfer;

  // rank_m1 wraps for rank_q==0, but that case is already forced to bypass.
  assign rank_m1 = rank_q - RANK_W'(1);
  assign byp     = is_bypass(uv_q, rank_q == '0);
  assign last    = byp || (idx_q == rank_m1);
  assign xfer    = issue_i && cmd_ready_i;

  always_comb begin
    idx_d = idx_q;
    if (load_i) begin
      idx_d = '0;
    end else if (xfer && !last) begin
      idx_d = idx_q + RANK_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rank_q <= '0;
      uv_q   <= 1'b0;
      idx_q  <= '0;
    end else begin
      if (load_i) begin
        rank_q <= rank_no_i;
        uv_q   <= uv_en_i;
      end
      idx_q <= idx_d;
    end
  end

  // Fields only change on a transfer, so they stay put while the consumer stalls.
  assign cmd_valid_o    = issue_i;
  assign cmd_layer_o    = issue_i ? layer_i : '0;
  assign cmd_rank_idx_o = (issue_i && !byp) ? idx_q : '0;
  assign cmd_bypass_o   = issue_i && byp;
  assign cmd_last_o     = issue_i && last;
  assign xfer_o         = xfer;

endmodule

// File: rtl/root_rank_sched.sv
// Per-inference layer sequencer: walks layers 0..last_layer, issues rank or bypass
// commands for each, and waits for the PE array acknowledge before advancing.
module root_rank_sched
  import root_rank_sched_pkg::*;
#(
  parameter int LAYER_W = LAYER_W_DEF,
  parameter int RANK_W  = RANK_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LAYER_W-1:0] last_layer,
  output logic [LAYER_W-1:0] lookup_layer,
  input  logic [RANK_W-1:0]  rank_no,
  input  logic               uv_en,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [LAYER_W-1:0] cmd_layer,
  output logic [RANK_W-1:0]  cmd_rank_idx,
  output logic               cmd_bypass,
  output logic               cmd_last,
  input  logic               layer_done,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  logic [1:0]         state_q, state_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [LAYER_W-1:0] last_q, last_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               xfer;

  rank_cmd_gen #(
    .LAYER_W (LAYER_W),
    .RANK_W  (RANK_W)
  ) u_cmd_gen (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .load_i         (state_q == ST_LOAD),
    .issue_i        (state_q == ST_ISSUE),
    .rank_no_i      (rank_no),
    .uv_en_i        (uv_en),
    .layer_i        (layer_q),
    .cmd_ready_i    (cmd_ready),
    .cmd_valid_o    (cmd_valid),
    .cmd_layer_o    (cmd_layer),
    .cmd_rank_idx_o (cmd_rank_idx),
    .cmd_bypass_o   (cmd_bypass),
    .cmd_last_o     (cmd_last),
    .xfer_o         (xfer)
  );

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    last_d  = last_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          last_d  = last_layer;
          layer_d = '0;
          err_d   = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (uv_en && (rank_no == '0)) begin
          err_d = 1'b1;
        end
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (xfer && cmd_last) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // layer_done is only honoured here; earlier pulses are deliberately lost.
        if (layer_done) begin
          if (layer_q == last_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            layer_d = layer_q + LAYER_W'(1);
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      layer_q <= '0;
      last_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      last_q  <= last_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign lookup_layer = layer_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign cfg_err      = err_q;

endmodule

// File: tb/tb_root_rank_sched.sv
// Bench for root_rank_sched: a rank table model feeds the lookup, an expected command
// list is built from the layer rules, and outputs are compared on the falling edge.
module tb_root_rank_sched;

  localparam int LAYER_W = 3;
  localparam int RANK_W  = 8;
  localparam int NL      = 1 << LAYER_W;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [LAYER_W-1:0] last_layer = '0;
  logic [LAYER_W-1:0] lookup_layer;
  logic [RANK_W-1:0]  rank_no;
  logic               uv_en;
  logic               cmd_valid;
  logic               cmd_ready = 1'b0;
  logic [LAYER_W-1:0] cmd_layer;
  logic [RANK_W-1:0]  cmd_rank_idx;
  logic               cmd_bypass;
  logic               cmd_last;
  logic               layer_done = 1'b0;
  logic               busy;
  logic               done;
  logic               cfg_err;

  logic [RANK_W-1:0]  rank_tbl [NL];
  logic               uv_tbl   [NL];

  assign rank_no = rank_tbl[lookup_layer];
  assign uv_en   = uv_tbl[lookup_layer];

  always #5 clk = ~clk;

  root_rank_sched #(.LAYER_W(LAYER_W), .RANK_W(RANK_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .last_layer   (last_layer),
    .lookup_layer (lookup_layer),
    .rank_no      (rank_no),
    .uv_en        (uv_en),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_layer    (cmd_layer),
    .cmd_rank_idx (cmd_rank_idx),
    .cmd_bypass   (cmd_bypass),
    .cmd_last     (cmd_last),
    .layer_done   (layer_done),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err)
  );

  typedef struct packed {
    logic [LAYER_W-1:0] layer;
    logic [RANK_W-1:0]  idx;
    logic               byp;
    logic               last;
  } cmd_t;

  cmd_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic clear_tbl();
    for (int l = 0; l < NL; l++) begin
      rank_tbl[l] = '0;
      uv_tbl[l]   = 1'b0;
    end
  endtask

  task automatic set_layer(input int l, input logic uv, input int rank);
    uv_tbl[l]   = uv;
    rank_tbl[l] = RANK_W'(rank);
  endtask

  // Expected command stream and error flag for one inference.
  task automatic build_exp(input int last, output bit err);
    cmd_t c;
    exp_q.delete();
    err = 1'b0;
    for (int l = 0; l <= last; l++) begin
      if (uv_tbl[l] && rank_tbl[l] != 0) begin
        for (int i = 0; i < int'(rank_tbl[l]); i++) begin
          c.layer = LAYER_W'(l);
          c.idx   = RANK_W'(i);
          c.byp   = 1'b0;
          c.last  = (i == int'(rank_tbl[l]) - 1);
          exp_q.push_back(c);
        end
      end else begin
        c.layer = LAYER_W'(l);
        c.idx   = '0;
        c.byp   = 1'b1;
        c.last  = 1'b1;
        exp_q.push_back(c);
        if (uv_tbl[l]) err = 1'b1;
      end
    end
  endtask

  // rmode: 0 always ready, 1 pattern 1,0,0,1..., 2 random ready.
  task automatic run_inf(input int last, input int rmode, input string name);
    bit   err;
    int   cur;
    int   wait_cnt;
    int   post_ld;
    int   rp;
    bit   fin;
    cmd_t c;
    logic [3:0] pat;
    pat = 4'b1001;
    build_exp(last, err);
    cur = 0; wait_cnt = -1; post_ld = 0; rp = 0; fin = 1'b0;

    @(negedge clk);
    start      = 1'b1;
    last_layer = LAYER_W'(last);
    @(negedge clk);
    start      = 1'b0;
    last_layer = LAYER_W'($urandom);
    check({name, ":busy_load"}, 32'(busy), 32'd1);
    check({name, ":err_clr"}, 32'(cfg_err), 32'd0);
    check({name, ":valid_load"}, 32'(cmd_valid), 32'd0);
    check({name, ":lookup0"}, 32'(lookup_layer), 32'd0);

    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      layer_done = 1'b0;
      start      = 1'b0;
      case (rmode)
        0:       cmd_ready = 1'b1;
        1:       cmd_ready = pat[rp % 4];
        default: cmd_ready = ($urandom_range(0, 99) < 65);
      endcase
      rp++;
      if (cyc == 1) check({name, ":first_valid"}, 32'(cmd_valid), 32'd1);
      if (done && !(post_ld == 1 && cur == last)) check({name, ":spurious_done"}, 32'(done), 32'd0);

      if (post_ld == 1) begin
        if (cur == last) begin
          check({name, ":done"}, 32'(done), 32'd1);
          check({name, ":busy_end"}, 32'(busy), 32'd0);
          check({name, ":cfg_err"}, 32'(cfg_err), 32'(err));
          check({name, ":all_cmds"}, 32'(exp_q.size()), 32'd0);
        end else begin
          check({name, ":valid_reload"}, 32'(cmd_valid), 32'd0);
          check({name, ":lookup_step"}, 32'(lookup_layer), 32'(cur + 1));
          cur++;
        end
        post_ld = 2;
      end else if (post_ld == 2) begin
        if (cur == last && !busy) begin
          check({name, ":done_pulse"}, 32'(done), 32'd0);
          fin = 1'b1;
        end else begin
          check({name, ":next_valid"}, 32'(cmd_valid), 32'd1);
        end
        post_ld = 0;
      end

      if (!fin && cmd_valid) begin
        if (exp_q.size() == 0) begin
          check({name, ":extra_cmd"}, 32'(cmd_valid), 32'd0);
          fin = 1'b1;
        end else begin
          c = exp_q[0];
          check({name, ":cmd"}, 32'({cmd_layer, cmd_rank_idx, cmd_bypass, cmd_last}), 32'(c));
          check({name, ":lookup"}, 32'(lookup_layer), 32'(c.layer));
          layer_done = ($urandom_range(0, 3) == 0);
          start      = ($urandom_range(0, 4) == 0);
          if (cmd_ready) begin
            void'(exp_q.pop_front());
            if (c.last) wait_cnt = $urandom_range(0, 4);
          end
        end
      end else if (!fin && wait_cnt > 0) begin
        wait_cnt--;
      end else if (!fin && wait_cnt == 0) begin
        check({name, ":wait_idle"}, 32'(cmd_valid), 32'd0);
        layer_done = 1'b1;
        wait_cnt   = -1;
        post_ld    = 1;
      end
      if (!fin) @(negedge clk);
    end
    layer_done = 1'b0;
    start      = 1'b0;
    if (!fin) check({name, ":timeout"}, 32'd0, 32'd1);
  endtask

  task automatic reset_mid();
    bit hit;
    clear_tbl();
    set_layer(0, 1'b1, 5);
    set_layer(1, 1'b1, 2);
    hit = 1'b0;
    @(negedge clk);
    start      = 1'b1;
    last_layer = 3'd1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      if (cmd_valid && cmd_rank_idx == 8'd2) begin
        hit       = 1'b1;
        cmd_ready = 1'b0;
        rst_n     = 1'b0;
      end else begin
        cmd_ready = 1'b1;
        @(negedge clk);
      end
    end
    check("rst:reached_idx2", 32'(hit), 32'd1);
    @(negedge clk);
    check("rst:valid", 32'(cmd_valid), 32'd0);
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:lookup", 32'(lookup_layer), 32'd0);
    check("rst:done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst:still_idle", 32'(busy), 32'd0);
    run_inf(1, 0, "replay");
  endtask

  initial begin
    clear_tbl();
    #2;
    check("reset:valid", 32'(cmd_valid), 32'd0);
    check("reset:busy", 32'(busy), 32'd0);
    check("reset:done", 32'(done), 32'd0);
    check("reset:err", 32'(cfg_err), 32'd0);
    check("reset:lookup", 32'(lookup_layer), 32'd0);
    check("reset:fields", 32'({cmd_layer, cmd_rank_idx, cmd_bypass, cmd_last}), 32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    clear_tbl();
    set_layer(0, 1'b1, 3);
    run_inf(0, 0, "single");

    clear_tbl();
    set_layer(0, 1'b1, 2);
    set_layer(1, 1'b0, 7);
    set_layer(2, 1'b1, 1);
    run_inf(2, 0, "mixed");

    clear_tbl();
    set_layer(0, 1'b1, 4);
    run_inf(0, 1, "backpressure");

    clear_tbl();
    set_layer(0, 1'b1, 0);
    run_inf(0, 2, "err");

    clear_tbl();
    set_layer(0, 1'b1, 2);
    run_inf(0, 0, "err_clear");

    clear_tbl();
    set_layer(0, 1'b1, 255);
    set_layer(1, 1'b0, 0);
    run_inf(1, 0, "maxrank");

    reset_mid();

    for (int t = 0; t < 8; t++) begin
      for (int l = 0; l < NL; l++) set_layer(l, ($urandom_range(0, 3) != 0), $urandom_range(0, 5));
      run_inf($urandom_range(0, NL - 1), 2, "random");
    end

    clear_tbl();
    for (int l = 0; l < NL; l++) set_layer(l, 1'b1, l + 1);
    run_inf(NL - 1, 1, "all_layers");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
